// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared definitions for the NOR-gate response checker.
//   - gate_chk_state_e : checker FSM state encoding
//   - SETTLE_W         : width of the settle-time down-counter
//   - gate_chk_expected: reference function of the gate under test (NOR2)
package gate_chk_pkg;

  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } gate_chk_state_e;

  function automatic logic gate_chk_expected(input logic a, input logic b);
    return ~(a | b);
  endfunction

endpackage

// File: rtl/gate_chk_sat_cnt.sv
// gate_chk_sat_cnt: W-bit up-counter that sticks at all-ones.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count one event
//   cnt        : current count
module gate_chk_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: accepts an A/B pair applied to a NOR2 gate through a
// valid/ready handshake, waits SETTLE_CYCLES, then samples C and scores it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : arms the checker from IDLE
//   clear               : synchronous clear of counters, error record, state
//   in_valid / in_ready : stimulus handshake
//   A, B, C             : gate inputs and gate output under test
//   busy                : not IDLE
//   pass_cnt, fail_cnt  : saturating result counters
//   err, last_fail_ab   : sticky error flag and {A,B} of latest failure
//   cov_mask, cov_done  : per-pair pass coverage (macro GATE_CHK_COVERAGE_EN;
//                         tied to 0 when the macro is undefined)
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [1:0]       last_fail_ab,
  output logic [3:0]       cov_mask,
  output logic             cov_done
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  gate_chk_state_e      state_d, state_q;
  logic [1:0]           ab_d, ab_q;
  logic [SETTLE_W-1:0]  cnt_d, cnt_q;
  logic                 unstable_d, unstable_q;
  logic                 err_d, err_q;
  logic [1:0]           last_fail_ab_d, last_fail_ab_q;
  logic                 pass_inc, fail_inc;

  always_comb begin
    state_d        = state_q;
    ab_d           = ab_q;
    cnt_d          = cnt_q;
    unstable_d     = unstable_q;
    err_d          = err_q;
    last_fail_ab_d = last_fail_ab_q;
    pass_inc       = 1'b0;
    fail_inc       = 1'b0;

    if (clear) begin
      state_d        = ST_IDLE;
      cnt_d          = '0;
      unstable_d     = 1'b0;
      err_d          = 1'b0;
      last_fail_ab_d = 2'b00;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (in_valid) begin
            ab_d    = {A, B};
            cnt_d   = SETTLE_LOAD;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if ({A, B} != ab_q) unstable_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q - SETTLE_W'(1);
          end
        end
        ST_CHECK: begin
          // Case inequality so an X/Z on C scores as a failure.
          if ((C !== gate_chk_expected(ab_q[1], ab_q[0])) || unstable_q) begin
            fail_inc       = 1'b1;
            err_d          = 1'b1;
            last_fail_ab_d = ab_q;
          end else begin
            pass_inc = 1'b1;
          end
          unstable_d = 1'b0;
          state_d    = ST_ARMED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ab_q           <= 2'b00;
      cnt_q          <= '0;
      unstable_q     <= 1'b0;
      err_q          <= 1'b0;
      last_fail_ab_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      ab_q           <= ab_d;
      cnt_q          <= cnt_d;
      unstable_q     <= unstable_d;
      err_q          <= err_d;
      last_fail_ab_q <= last_fail_ab_d;
    end
  end

  gate_chk_sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (pass_inc),
    .cnt   (pass_cnt)
  );

  gate_chk_sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (fail_inc),
    .cnt   (fail_cnt)
  );

`ifdef GATE_CHK_COVERAGE_EN
  logic [3:0] cov_mask_d, cov_mask_q;
  logic       cov_done_d, cov_done_q;

  // cov_done is registered from the next mask value so both move on the same edge.
  always_comb begin
    cov_mask_d = cov_mask_q;
    if (clear) begin
      cov_mask_d = '0;
    end else if (pass_inc) begin
      cov_mask_d[ab_q] = 1'b1;
    end
    cov_done_d = &cov_mask_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov_mask_q <= '0;
      cov_done_q <= 1'b0;
    end else begin
      cov_mask_q <= cov_mask_d;
      cov_done_q <= cov_done_d;
    end
  end

  assign cov_mask = cov_mask_q;
  assign cov_done = cov_done_q;
`else
  assign cov_mask = '0;
  assign cov_done = 1'b0;
`endif

  assign in_ready     = (state_q == ST_ARMED);
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;
  assign last_fail_ab = last_fail_ab_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: two instances (CNT_W=8 and
// CNT_W=2) share all stimulus; the bench drives C itself, predicts the
// outcome of every accepted pair and checks both instances when the
// checker returns to ARMED.
module tb_gate_response_checker;

  localparam int unsigned S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, clear, in_valid, A, B, C;
  logic in_ready, busy, err;
  logic [7:0] pass_cnt, fail_cnt;
  logic [1:0] last_fail_ab;
  logic [3:0] cov_mask;
  logic       cov_done;
  logic in_ready2, busy2, err2;
  logic [1:0] pass_cnt2, fail_cnt2;
  logic [1:0] last_fail_ab2;
  logic [3:0] cov_mask2;
  logic       cov_done2;

  gate_response_checker #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .C(C),
    .busy(busy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
    .last_fail_ab(last_fail_ab), .cov_mask(cov_mask), .cov_done(cov_done)
  );

  gate_response_checker #(.SETTLE_CYCLES(S), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready2), .A(A), .B(B), .C(C),
    .busy(busy2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .err(err2),
    .last_fail_ab(last_fail_ab2), .cov_mask(cov_mask2), .cov_done(cov_done2)
  );

  typedef struct {
    logic [1:0] ab;
    logic       pass;
  } item_t;

  item_t sb_q[$];

  int n_vec = 0;
  int n_bad = 0;

  int         m_pass, m_fail, m_pass2, m_fail2;
  logic       m_err;
  logic [1:0] m_last;
  logic [3:0] m_cov;
  logic       m_cov_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      n_bad++;
    end
  endtask

  task automatic model_reset();
    m_pass = 0; m_fail = 0; m_pass2 = 0; m_fail2 = 0;
    m_err = 1'b0; m_last = 2'b00; m_cov = 4'h0; m_cov_done = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_pass"},  32'(pass_cnt),  32'(m_pass));
    check_eq({tag, "_fail"},  32'(fail_cnt),  32'(m_fail));
    check_eq({tag, "_pass2"}, 32'(pass_cnt2), 32'(m_pass2));
    check_eq({tag, "_fail2"}, 32'(fail_cnt2), 32'(m_fail2));
    check_eq({tag, "_err"},   32'(err),       32'(m_err));
    check_eq({tag, "_err2"},  32'(err2),      32'(m_err));
    check_eq({tag, "_last"},  32'(last_fail_ab), 32'(m_last));
    check_eq({tag, "_cov"},   32'(cov_mask),  32'(m_cov));
    check_eq({tag, "_cdone"}, 32'(cov_done),  32'(m_cov_done));
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Drive one pair with the given C; glitch flips B in the first SETTLE cycle.
  task automatic apply_pair(input string tag, input logic [1:0] ab, input logic c_val,
                            input logic glitch);
    item_t it;
    int k;
    @(negedge clk);
    A = ab[1]; B = ab[0]; C = c_val; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check_eq({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    it.ab   = ab;
    it.pass = (c_val === ~(ab[1] | ab[0])) && !glitch;
    sb_q.push_back(it);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_settle_rdy"},  32'(in_ready), 32'd0);
    check_eq({tag, "_settle_busy"}, 32'(busy),     32'd1);
    if (glitch) B = ~B;
    k = 1;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_latency"}, 32'(k), 32'(S + 2));
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    it = sb_q.pop_front();
    if (it.pass) begin
      if (m_pass < 255) m_pass++;
      if (m_pass2 < 3)  m_pass2++;
`ifdef GATE_CHK_COVERAGE_EN
      m_cov[it.ab] = 1'b1;
      m_cov_done   = &m_cov;
`endif
    end else begin
      if (m_fail < 255) m_fail++;
      if (m_fail2 < 3)  m_fail2++;
      m_err  = 1'b1;
      m_last = it.ab;
    end
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    A = 1'b0; B = 1'b0; C = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_busy",  32'(busy),     32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);

    start_pulse();
    check_eq("armed_ready", 32'(in_ready), 32'd1);
    check_eq("armed_busy",  32'(busy),     32'd1);

    // Correct gate over all four pairs, then a fifth to saturate CNT_W=2.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] p;
      p = 2'(i);
      apply_pair("good", p, ~(p[1] | p[0]), 1'b0);
    end
    apply_pair("good5", 2'b11, 1'b0, 1'b0);

    // start while ARMED is ignored.
    start_pulse();
    check_eq("start_ign_rdy", 32'(in_ready), 32'd1);

    apply_pair("stuck0", 2'b00, 1'b0, 1'b0);
    apply_pair("glitch", 2'b01, 1'b0, 1'b1);
    apply_pair("stuck1", 2'b10, 1'b1, 1'b0);

    // clear together with a valid pair: nothing captured, back to IDLE.
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; A = 1'b1; B = 1'b1; C = 1'b0;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    check_eq("clr_busy",  32'(busy),     32'd0);
    check_eq("clr_ready", 32'(in_ready), 32'd0);
    check_outputs("clr");
    repeat (2) @(negedge clk);
    check_eq("clr_stay_idle", 32'(busy), 32'd0);
    start_pulse();
    check_eq("clr_rearm_rdy", 32'(in_ready), 32'd1);
    apply_pair("after_clr", 2'b01, 1'b0, 1'b0);

    // Async reset in SETTLE abandons the check.
    @(negedge clk);
    A = 1'b1; B = 1'b1; C = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("pre_rst_settle", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_busy",  32'(busy),     32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
    check_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (S + 3) @(negedge clk);
    check_eq("post_rst_fail", 32'(fail_cnt), 32'd0);
    start_pulse();
    apply_pair("post_rst", 2'b11, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
